ps2_scan_sequencer: RTL and testbench

//  Consumes the one-cycle scan-code pulses of the PS/2 receiver (CODEWORD/scan_err) and sequences
//  set-2 prefix bytes (E0 extended, F0 break) into complete key events. Events are buffered in a

---
 rtl/ps2_scan_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ps2_scan_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_sequencer.sv
// Turns PS/2 set-2 byte strobes (E0/F0 prefixes) into key events, queued in a small FIFO with valid/ready.
// Latency: strobe in cycle N -> event visible N+1; when full without a pop, the new event is dropped (sticky OVERFLOW).
module ps2_scan_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  CODEWORD,
    input  logic        SCAN_ERR,
    output logic        EVT_VALID,
    input  logic        EVT_READY,
    output logic [7:0]  EVT_CODE,
    output logic        EVT_EXT,
    output logic        EVT_BREAK,
    output logic        EVT_REPEAT,
    output logic [11:0] PAD_HELD,
    output logic        OVERFLOW,
    input  logic        OVF_CLR,
    output logic [7:0]  ERR_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
    } evt_t;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [11:0]   pad_q, pad_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    evt_t          head_q, head_d;
    evt_t          mem_q [FIFO_DEPTH];

    logic          strobe, is_e0, is_f0, is_e1;
    logic          push_vld, push_ok, pop, full, drop;
    logic [AW:0]   remain;
    logic [3:0]    kp;
    evt_t          push_dat;

    // Keypad scan code -> held-map bit; 4'hF means not a keypad key.
    function automatic logic [3:0] kp_idx(input logic [7:0] c);
        case (c)
            8'h70:   kp_idx = 4'd0;
            8'h69:   kp_idx = 4'd1;
            8'h72:   kp_idx = 4'd2;
            8'h7A:   kp_idx = 4'd3;
            8'h6B:   kp_idx = 4'd4;
            8'h73:   kp_idx = 4'd5;
            8'h74:   kp_idx = 4'd6;
            8'h6C:   kp_idx = 4'd7;
            8'h75:   kp_idx = 4'd8;
            8'h7D:   kp_idx = 4'd9;
            8'h71:   kp_idx = 4'd10;
            8'h7B:   kp_idx = 4'd11;
            default: kp_idx = 4'hF;
        endcase
    endfunction

    always_comb begin
        strobe    = (CODEWORD != 8'h00);
        is_e0     = (CODEWORD == 8'hE0);
        is_f0     = (CODEWORD == 8'hF0);
        is_e1     = (CODEWORD == 8'hE1);
        kp        = kp_idx(CODEWORD);
        state_d   = state_q;
        tmo_d     = tmo_q;
        err_cnt_d = err_cnt_q;
        pad_d     = pad_q;
        push_vld  = 1'b0;
        push_dat  = '0;
        push_dat.code = CODEWORD;

        if (strobe) begin
            tmo_d = '0;
            if (SCAN_ERR) begin
                state_d = S_IDLE;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (is_e0)       state_d = S_EXT;
                        else if (is_f0)  state_d = S_BRK;
                        else if (!is_e1) push_vld = 1'b1;
                    end
                    S_EXT: begin
                        if (is_f0) state_d = S_EXT_BRK;
                        else if (!is_e0) begin
                            push_vld     = 1'b1;
                            push_dat.ext = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        state_d      = S_IDLE;
                        push_vld     = !(is_f0 || is_e0);
                        push_dat.brk = 1'b1;
                    end
                    default: begin
                        state_d      = S_IDLE;
                        push_vld     = !(is_f0 || is_e0 || is_e1);
                        push_dat.ext = 1'b1;
                        push_dat.brk = 1'b1;
                    end
                endcase
            end
        end else if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        // The held map tracks the key itself, so it updates even when the FIFO drops the event.
        if (push_vld && !push_dat.ext && kp != 4'hF) begin
            if (push_dat.brk) begin
                pad_d[kp] = 1'b0;
            end else begin
                push_dat.rpt = pad_q[kp];
                pad_d[kp]    = 1'b1;
            end
        end
    end

    always_comb begin
        pop      = EVT_VALID && EVT_READY;
        full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
        push_ok  = push_vld && (!full || pop);
        drop     = push_vld && full && !pop;
        ovf_d    = OVF_CLR ? 1'b0 : (ovf_q | drop);
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        remain   = pop ? cnt_q - 1'b1 : cnt_q;
        cnt_d    = push_ok ? remain + 1'b1 : remain;
        head_d   = head_q;
        // Bypass the new event straight to the output when nothing older remains.
        if (cnt_d != '0) begin
            if (remain == '0) head_d = push_dat;
            else              head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            err_cnt_q <= '0;
            pad_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            head_q    <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
            pad_q     <= pad_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            head_q    <= head_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

    assign EVT_VALID  = (cnt_q != '0);
    assign EVT_CODE   = head_q.code;
    assign EVT_EXT    = head_q.ext;
    assign EVT_BREAK  = head_q.brk;
    assign EVT_REPEAT = head_q.rpt;
    assign PAD_HELD   = pad_q;
    assign OVERFLOW   = ovf_q;
    assign ERR_COUNT  = err_cnt_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed scenarios plus random byte streams, compared cycle by cycle against a queue-based model.
module tb_ps2_scan_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 4000;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  CODEWORD = 8'h00;
    logic        SCAN_ERR = 1'b0;
    logic        EVT_READY = 1'b0;
    logic        OVF_CLR = 1'b0;
    logic        EVT_VALID, EVT_EXT, EVT_BREAK, EVT_REPEAT, OVERFLOW;
    logic [7:0]  EVT_CODE, ERR_COUNT;
    logic [11:0] PAD_HELD;

    ps2_scan_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .CODEWORD(CODEWORD), .SCAN_ERR(SCAN_ERR),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
        .EVT_EXT(EVT_EXT), .EVT_BREAK(EVT_BREAK), .EVT_REPEAT(EVT_REPEAT),
        .PAD_HELD(PAD_HELD), .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    logic [7:0] kp_tab [12] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
                                8'h74, 8'h6C, 8'h75, 8'h7D, 8'h71, 8'h7B};

    ev_t         q[$];
    ev_t         last;
    logic        m_ext, m_brk, m_ovf;
    logic [11:0] m_held;
    int          m_err, gap;
    int          passed = 0;
    int          total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ev_t emit(input logic [7:0] c, input logic e, input logic b);
        ev_t ev;
        int  idx = -1;
        for (int i = 0; i < 12; i++) if (kp_tab[i] == c) idx = i;
        ev = '{code: c, ext: e, brk: b, rpt: 1'b0};
        if (!e && idx >= 0) begin
            if (b) m_held[idx] = 1'b0;
            else begin
                ev.rpt      = m_held[idx];
                m_held[idx] = 1'b1;
            end
        end
        return ev;
    endfunction

    task automatic model_reset();
        q.delete();
        last   = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_ovf  = 1'b0;
        m_held = '0;
        m_err  = 0;
        gap    = 0;
    endtask

    // Prefix flags survive at most TMO-1 idle cycles before the next byte.
    task automatic model_byte(input logic [7:0] c, input logic err, output logic has, output ev_t ev);
        logic pre;
        has = 1'b0;
        ev  = '0;
        pre = (c == 8'hE0) || (c == 8'hF0) || (c == 8'hE1);
        if (c == 8'h00) begin
            gap++;
        end else begin
            if (gap >= TMO) begin m_ext = 1'b0; m_brk = 1'b0; end
            gap = 0;
            if (err) begin
                if (m_err < 255) m_err++;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (!m_ext && !m_brk) begin
                if (c == 8'hE0)      m_ext = 1'b1;
                else if (c == 8'hF0) m_brk = 1'b1;
                else if (c != 8'hE1) begin has = 1'b1; ev = emit(c, 1'b0, 1'b0); end
            end else if (m_ext && !m_brk) begin
                if (c == 8'hF0) m_brk = 1'b1;
                else if (c != 8'hE0) begin has = 1'b1; ev = emit(c, 1'b1, 1'b0); m_ext = 1'b0; end
            end else if (!m_ext && m_brk) begin
                if (c != 8'hF0 && c != 8'hE0) begin has = 1'b1; ev = emit(c, 1'b0, 1'b1); end
                m_brk = 1'b0;
            end else begin
                if (!pre) begin has = 1'b1; ev = emit(c, 1'b1, 1'b1); end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    // Called at a negedge: check current outputs, then drive one cycle of inputs.
    task automatic step(input logic [7:0] c, input logic err, input logic rdy, input logic clr);
        ev_t  exp_h, ev;
        logic has;
        exp_h = (q.size() > 0) ? q[0] : last;
        if (q.size() > 0) last = q[0];
        chk("evt_valid", EVT_VALID, q.size() > 0);
        chk("evt_code", EVT_CODE, exp_h.code);
        chk("evt_ext", EVT_EXT, exp_h.ext);
        chk("evt_break", EVT_BREAK, exp_h.brk);
        chk("evt_repeat", EVT_REPEAT, exp_h.rpt);
        chk("pad_held", PAD_HELD, m_held);
        chk("overflow", OVERFLOW, m_ovf);
        chk("err_count", ERR_COUNT, m_err);
        CODEWORD  = c;
        SCAN_ERR  = err;
        EVT_READY = rdy;
        OVF_CLR   = clr;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        model_byte(c, err, has, ev);
        if (has) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        CODEWORD  = 8'h00;
        SCAN_ERR  = 1'b0;
        EVT_READY = 1'b0;
        OVF_CLR   = 1'b0;
        RST_N     = 1'b0;
        #1;
        chk("rst_valid", EVT_VALID, 0);
        chk("rst_code", EVT_CODE, 0);
        chk("rst_flags", {EVT_EXT, EVT_BREAK, EVT_REPEAT}, 0);
        chk("rst_pad", PAD_HELD, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_err", ERR_COUNT, 0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] c;
        int         r;
        model_reset();
        @(negedge CLK);
        do_reset();

        // make/break of a plain key
        step(8'h16, 0, 1, 0); step(8'hF0, 0, 1, 0); step(8'h16, 0, 1, 0); idle(3, 1);
        // extended keypad-8 code never touches the map
        step(8'hE0, 0, 1, 0); step(8'h75, 0, 1, 0);
        step(8'hE0, 0, 1, 0); step(8'hF0, 0, 1, 0); step(8'h75, 0, 1, 0); idle(2, 1);
        chk("ext_pad_untouched", PAD_HELD, 12'h000);
        // keypad typematic and release
        step(8'h69, 0, 1, 0);
        chk("kp1_held", PAD_HELD[1], 1);
        step(8'h69, 0, 1, 0); step(8'hF0, 0, 1, 0); step(8'h69, 0, 1, 0); idle(2, 1);
        chk("kp1_released", PAD_HELD[1], 0);

        // fill, overflow, clear, then push+pop while full
        step(8'h1C, 0, 0, 0); step(8'h1B, 0, 0, 0); step(8'h23, 0, 0, 0);
        step(8'h2B, 0, 0, 0); step(8'h34, 0, 0, 0); idle(1, 0);
        chk("ovf_set", OVERFLOW, 1);
        step(8'h00, 0, 0, 1);
        step(8'h33, 0, 1, 0);
        step(8'h00, 0, 0, 0);
        chk("ovf_cleared", OVERFLOW, 0);
        idle(6, 1);

        // prefix timeout boundary: one cycle short keeps the break, TMO idle cycles drops it
        step(8'hF0, 0, 1, 0); idle(TMO - 1, 1); step(8'h1C, 0, 1, 0); idle(2, 1);
        step(8'hF0, 0, 1, 0); idle(TMO, 1);     step(8'h1C, 0, 1, 0); idle(2, 1);
        chk("tmo_press", {EVT_CODE, EVT_BREAK}, {8'h1C, 1'b0});

        // errored byte inside a break sequence
        step(8'hF0, 0, 1, 0); step(8'h1C, 1, 1, 0); step(8'h1C, 0, 1, 0); idle(2, 1);
        chk("err_one", ERR_COUNT, 1);

        // reset in the middle of an E0 sequence
        step(8'hE0, 0, 1, 0);
        do_reset();
        step(8'h75, 0, 1, 0); idle(2, 1);
        chk("post_rst_press", {EVT_CODE, EVT_EXT}, {8'h75, 1'b0});

        // random byte streams with random consumer stalls
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      c = 8'h00;
            else if (r < 35) c = 8'hE0;
            else if (r < 45) c = 8'hF0;
            else if (r < 48) c = 8'hE1;
            else if (r < 75) c = kp_tab[$urandom_range(0, 11)];
            else             c = 8'($urandom_range(1, 255));
            step(c, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        idle(6, 1);

        // error counter saturation
        for (int n = 0; n < 260; n++) step(8'h1C, 1, 1, 0);
        idle(1, 1);
        chk("err_sat", ERR_COUNT, 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
